// File: rtl/framebuffer_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : framebuffer_reader
// Purpose  : Scanout engine for the read-only port of the pixel framebuffer.
//            It sweeps addresses 0..DEPTH-1 once per frame and absorbs the
//            1-cycle registered read latency with a 2-entry output buffer.
//            Pixels leave in raster order on a valid/ready stream that
//            carries start-of-frame, end-of-line and end-of-frame markers.
//
// Ports    : clk         - single clock, shared with the framebuffer read port
//            resetN      - asynchronous active-low reset
//            start       - 1-cycle pulse that begins a frame (ignored if busy)
//            busy        - frame in progress
//            frameDone   - 1-cycle pulse with the final pixel handshake
//            fbAddress   - framebuffer read address
//            fbData      - framebuffer read data, 1 cycle after fbAddress
//            pixelData   - output pixel
//            pixelValid  - pixelData and the flags are valid
//            pixelReady  - downstream accepts (transfer on valid && ready)
//            firstPixel  - marks pixel index 0
//            lastInLine  - marks column LINE_PIXELS-1
//            lastPixel   - marks pixel index DEPTH-1
//
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_reader #(
    parameter int WIDTH       = 9,
    parameter int DEPTH       = 2048,
    parameter int LINE_PIXELS = 64,
    parameter int LINES       = 32
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     start,
    output logic                     busy,
    output logic                     frameDone,
    output logic [$clog2(DEPTH)-1:0] fbAddress,
    input  logic [WIDTH-1:0]         fbData,
    output logic [WIDTH-1:0]         pixelData,
    output logic                     pixelValid,
    input  logic                     pixelReady,
    output logic                     firstPixel,
    output logic                     lastInLine,
    output logic                     lastPixel
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_COL_W  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;

    // The frame geometry defines the last word of the sweep; DEPTH only sizes
    // the address bus, and the two are required to agree.
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(LINE_PIXELS * LINES - 1);
    localparam logic [c_COL_W-1:0]  c_LAST_COL  = c_COL_W'(LINE_PIXELS - 1);
    localparam logic [c_ADDR_W-1:0] c_ADDR_ONE  = c_ADDR_W'(1);
    localparam logic [c_COL_W-1:0]  c_COL_ONE   = c_COL_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_ADDR_W-1:0] r_addr;       // next address to issue
    logic                r_inflight;   // a read was issued last cycle
    logic [WIDTH-1:0]    r_buf0;
    logic [WIDTH-1:0]    r_buf1;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;      // buffer occupancy, 0..2
    logic [c_ADDR_W-1:0] r_pix_idx;    // index of the pixel at the buffer head
    logic [c_COL_W-1:0]  r_col;        // column of the pixel at the buffer head

    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic                w_start;
    logic                w_frame_done;
    logic [2:0]          w_occ;

    // ------------------------------------------------------------------------
    // Handshake and issue control
    // ------------------------------------------------------------------------
    assign w_pop  = (r_count != 2'd0) && pixelReady;
    assign w_push = r_inflight;

    // Occupancy as seen after this cycle's pop, counting the read whose data
    // lands next cycle. Issuing only when this is below 2 guarantees the
    // returning word always has a free slot, regardless of pixelReady.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == c_FETCH) && (w_occ < 3'd2);

    assign w_start = (r_state == c_IDLE) && start;

    // The final pixel is the only thing left once the sweep is drained, so the
    // frame ends on its handshake.
    assign w_frame_done = (r_state == c_DRAIN) && w_pop && !r_inflight &&
                          (r_count == 2'd1) && (r_pix_idx == c_LAST_ADDR);

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (w_issue && (r_addr == c_LAST_ADDR)) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_frame_done) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read address: advances only on issue and parks on the last word until
    // the next accepted start, so it never wraps inside a frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_addr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start) begin
                r_addr <= '0;
            end else if (w_issue && (r_addr != c_LAST_ADDR)) begin
                r_addr <= r_addr + c_ADDR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Two-entry output buffer. Data returning from the framebuffer is written
    // the cycle after its read was issued.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_buf0   <= '0;
            r_buf1   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                if (r_wr_ptr) begin
                    r_buf1 <= fbData;
                end else begin
                    r_buf0 <= fbData;
                end
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // ------------------------------------------------------------------------
    // Position counters. They describe the pixel at the buffer head and move
    // only on an accepted transfer, so the flags stay stable under back
    // pressure.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pix_idx <= '0;
            r_col     <= '0;
        end else if (w_start) begin
            r_pix_idx <= '0;
            r_col     <= '0;
        end else if (w_pop) begin
            r_pix_idx <= (r_pix_idx == c_LAST_ADDR) ? '0 : (r_pix_idx + c_ADDR_ONE);
            r_col     <= (r_col == c_LAST_COL) ? '0 : (r_col + c_COL_ONE);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy       = (r_state != c_IDLE);
    assign frameDone  = w_frame_done;
    assign fbAddress  = r_addr;
    assign pixelValid = (r_count != 2'd0);
    assign pixelData  = r_rd_ptr ? r_buf1 : r_buf0;
    assign firstPixel = pixelValid && (r_pix_idx == '0);
    assign lastInLine = pixelValid && (r_col == c_LAST_COL);
    assign lastPixel  = pixelValid && (r_pix_idx == c_LAST_ADDR);

endmodule

`default_nettype wire
